// File: rtl/reg_file_sb_if.sv
// Register-file bus: control/datapath inputs and read, scoreboard and
// write-status outputs of the scoreboarded register file.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWre;
  logic [1:0]        RegDst;
  logic              DBDataSrc;
  logic [2:0]        state;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] ram_dataout;
  logic [DATA_W-1:0] address;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] dbg_data;
  logic              busy_rs;
  logic              busy_rt;
  logic              wr_ack;
  logic [15:0]       wr_count;

  modport master (
    output RegWre, RegDst, DBDataSrc, state,
    output rs, rt, rd, dbg_addr,
    output alu_result, ram_dataout, address,
    input  ReadData1, ReadData2, dbg_data,
    input  busy_rs, busy_rt, wr_ack, wr_count
  );

  modport slave (
    input  RegWre, RegDst, DBDataSrc, state,
    input  rs, rt, rd, dbg_addr,
    input  alu_result, ram_dataout, address,
    output ReadData1, ReadData2, dbg_data,
    output busy_rs, busy_rt, wr_ack, wr_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file with busy scoreboard, optional
// write-to-read bypass, debug port, write ack and write counter.
module reg_file_sb #(
  parameter int         DATA_W   = 32,
  parameter int         ADDR_W   = 5,
  parameter int         LINK_REG = 31,
  parameter int         BYPASS   = 1,
  parameter logic [2:0] ST_ID    = 3'b001,
  parameter logic [2:0] ST_WB    = 3'b011
) (
  input logic      CLK,
  input logic      RST,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX =
    ADDR_W'(LINK_REG);
  localparam logic [1:0] DST_LINK = 2'b00;
  localparam logic [1:0] DST_RT   = 2'b01;
  localparam logic [1:0] DST_RD   = 2'b10;

  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              wb_en;
  logic              link_en;
  logic              issue_en;
  logic              commit;
  logic              byp_rs;
  logic              byp_rt;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ack_q;
  logic              wr_ack_d;
  logic [15:0]       wr_cnt_q;
  logic [15:0]       wr_cnt_d;

  always_comb begin
    write_reg = '0;
    unique case (bus.RegDst)
      DST_LINK: write_reg = LINK_IDX;
      DST_RT:   write_reg = bus.rt;
      DST_RD:   write_reg = bus.rd;
      default:  write_reg = '0;
    endcase
  end

  assign write_data = bus.DBDataSrc ? bus.ram_dataout
                                    : bus.alu_result;

  assign wb_en = bus.RegWre
              && (bus.state == ST_WB)
              && (write_reg != '0);

  assign link_en = bus.RegWre
                && (bus.state == ST_ID)
                && (bus.RegDst == DST_LINK);

  assign issue_en = bus.RegWre
                 && (bus.state == ST_ID)
                 && ((bus.RegDst == DST_RT)
                  || (bus.RegDst == DST_RD))
                 && (write_reg != '0);

  assign commit = wb_en | link_en;

  // wb_en already excludes index 0, so a hit implies idx != 0
  assign byp_rs = (BYPASS != 0) && wb_en
               && (write_reg == bus.rs);
  assign byp_rt = (BYPASS != 0) && wb_en
               && (write_reg == bus.rt);

  always_comb begin
    bus.ReadData1 = rf_q[bus.rs];
    if (bus.rs == '0)
      bus.ReadData1 = '0;
    else if (byp_rs)
      bus.ReadData1 = write_data;

    bus.ReadData2 = rf_q[bus.rt];
    if (bus.rt == '0)
      bus.ReadData2 = '0;
    else if (byp_rt)
      bus.ReadData2 = write_data;

    bus.dbg_data = rf_q[bus.dbg_addr];
    if (bus.dbg_addr == '0)
      bus.dbg_data = '0;
  end

  assign bus.busy_rs  = (bus.rs != '0) && busy_q[bus.rs];
  assign bus.busy_rt  = (bus.rt != '0) && busy_q[bus.rt];
  assign bus.wr_ack   = wr_ack_q;
  assign bus.wr_count = wr_cnt_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      rf_d[i] = rf_q[i];
    busy_d   = busy_q;
    wr_ack_d = commit;
    wr_cnt_d = wr_cnt_q + {15'd0, commit};

    if (wb_en) begin
      rf_d[write_reg]   = write_data;
      busy_d[write_reg] = 1'b0;
    end
    if (link_en)
      rf_d[LINK_IDX] = bus.address + DATA_W'(4);
    if (issue_en)
      busy_d[write_reg] = 1'b1;

    rf_d[0]   = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(negedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        rf_q[i] <= '0;
      busy_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        rf_q[i] <= rf_d[i];
      busy_q   <= busy_d;
      wr_ack_q <= wr_ack_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed vectors, expected values
// queued by stimulus and checked by an independent monitor.
module tb_reg_file_sb;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1),
    .ST_ID(3'b001), .ST_WB(3'b011)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(0),
    .ST_ID(3'b001), .ST_WB(3'b011)
  ) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0)
  );

  assign bus0.RegWre      = bus.RegWre;
  assign bus0.RegDst      = bus.RegDst;
  assign bus0.DBDataSrc   = bus.DBDataSrc;
  assign bus0.state       = bus.state;
  assign bus0.rs          = bus.rs;
  assign bus0.rt          = bus.rt;
  assign bus0.rd          = bus.rd;
  assign bus0.alu_result  = bus.alu_result;
  assign bus0.ram_dataout = bus.ram_dataout;
  assign bus0.address     = bus.address;
  assign bus0.dbg_addr    = bus.dbg_addr;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  localparam int S_RD1  = 0;
  localparam int S_RD2  = 1;
  localparam int S_DBG  = 2;
  localparam int S_BRS  = 3;
  localparam int S_BRT  = 4;
  localparam int S_CNT  = 5;
  localparam int S_ACK  = 6;
  localparam int S_RD1N = 7;

  chk_t        chk_q[$];
  logic [15:0] ack_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_RD1:  return bus.ReadData1;
      S_RD2:  return bus.ReadData2;
      S_DBG:  return bus.dbg_data;
      S_BRS:  return {31'd0, bus.busy_rs};
      S_BRT:  return {31'd0, bus.busy_rt};
      S_CNT:  return {16'd0, bus.wr_count};
      S_ACK:  return {31'd0, bus.wr_ack};
      S_RD1N: return bus0.ReadData1;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: samples midway between committing (falling) edges
  always @(posedge CLK) begin
    chk_t        c;
    logic [31:0] a;
    logic [15:0] e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      a = obs(c.sel);
      n_chk++;
      if (a !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h",
                 c.name, a, c.exp);
      end
    end
    if (bus.wr_ack === 1'b1) begin
      n_chk++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_ack: got wr_ack=1 cnt=%h expected no ack",
                 bus.wr_count);
      end else begin
        e = ack_q.pop_front();
        if (bus.wr_count !== e) begin
          n_fail++;
          $display("FAIL ack_count: got %h expected %h",
                   bus.wr_count, e);
        end
      end
    end
  end

  task automatic expect_v(string n, int sel, logic [31:0] e);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic commit();
    exp_cnt = exp_cnt + 16'd1;
    ack_q.push_back(exp_cnt);
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.RegWre      = 1'b0;
    bus.RegDst      = 2'b11;
    bus.DBDataSrc   = 1'b0;
    bus.state       = 3'b000;
    bus.rd          = 5'd0;
    bus.alu_result  = 32'h0;
    bus.ram_dataout = 32'h0;
    bus.address     = 32'h0;
  endtask

  task automatic ctl(logic [2:0] st, logic [1:0] dst);
    bus.RegWre = 1'b1;
    bus.state  = st;
    bus.RegDst = dst;
  endtask

  initial begin
    idle();
    bus.rs       = 5'd5;
    bus.rt       = 5'd5;
    bus.dbg_addr = 5'd5;

    // reset with a write-back request present
    RST = 1'b0;
    ctl(3'b011, 2'b10);
    bus.rd         = 5'd5;
    bus.alu_result = 32'h1111_1111;
    tick();

    RST = 1'b1;
    idle();
    expect_v("rst_rd1", S_RD1, 32'h0);
    expect_v("rst_rd2", S_RD2, 32'h0);
    expect_v("rst_dbg", S_DBG, 32'h0);
    expect_v("rst_cnt", S_CNT, 32'h0);
    expect_v("rst_ack", S_ACK, 32'h0);
    tick();

    ctl(3'b011, 2'b10);
    bus.rd         = 5'd5;
    bus.alu_result = 32'h1234_5678;
    expect_v("wb5_bypass", S_RD1, 32'h1234_5678);
    expect_v("wb5_dbg_old", S_DBG, 32'h0);
    commit();
    tick();

    idle();
    bus.rt = 5'd7;
    expect_v("rd5", S_RD1, 32'h1234_5678);
    expect_v("dbg5", S_DBG, 32'h1234_5678);
    expect_v("cnt1", S_CNT, 32'd1);
    expect_v("ack1", S_ACK, 32'd1);
    tick();

    ctl(3'b011, 2'b01);
    bus.DBDataSrc   = 1'b1;
    bus.ram_dataout = 32'hDEAD_BEEF;
    bus.alu_result  = 32'h0BAD_0BAD;
    commit();
    tick();

    idle();
    bus.dbg_addr = 5'd7;
    expect_v("rd7", S_RD2, 32'hDEAD_BEEF);
    expect_v("dbg7", S_DBG, 32'hDEAD_BEEF);
    expect_v("cnt2", S_CNT, 32'd2);
    tick();

    ctl(3'b011, 2'b10);
    bus.rd         = 5'd3;
    bus.alu_result = 32'h0000_0033;
    commit();
    tick();

    ctl(3'b011, 2'b10);
    bus.rd         = 5'd3;
    bus.alu_result = 32'hA5A5_A5A5;
    bus.rs         = 5'd3;
    bus.dbg_addr   = 5'd3;
    expect_v("byp_on", S_RD1, 32'hA5A5_A5A5);
    expect_v("byp_off", S_RD1N, 32'h0000_0033);
    expect_v("byp_dbg_old", S_DBG, 32'h0000_0033);
    expect_v("b2b_ack_a", S_ACK, 32'd1);
    commit();
    tick();

    idle();
    expect_v("b2b_ack_b", S_ACK, 32'd1);
    expect_v("rd3_new", S_RD1, 32'hA5A5_A5A5);
    expect_v("rd3_new_nb", S_RD1N, 32'hA5A5_A5A5);
    expect_v("cnt4", S_CNT, 32'd4);
    tick();

    expect_v("ack_drop", S_ACK, 32'd0);
    tick();

    ctl(3'b001, 2'b00);
    bus.address = 32'h0000_0FFC;
    bus.rs      = 5'd31;
    expect_v("link_nobyp", S_RD1, 32'h0);
    commit();
    tick();

    ctl(3'b001, 2'b00);
    bus.address = 32'hFFFF_FFFC;
    expect_v("link1", S_RD1, 32'h0000_1000);
    expect_v("link_ack", S_ACK, 32'd1);
    commit();
    tick();

    idle();
    expect_v("link_wrap", S_RD1, 32'h0);
    expect_v("cnt6", S_CNT, 32'd6);
    tick();

    ctl(3'b001, 2'b01);
    bus.rt = 5'd9;
    bus.rs = 5'd9;
    expect_v("busy_pre", S_BRT, 32'd0);
    tick();

    idle();
    expect_v("busy_rt9", S_BRT, 32'd1);
    expect_v("busy_rs9", S_BRS, 32'd1);
    expect_v("issue_noack", S_ACK, 32'd0);
    tick();

    ctl(3'b011, 2'b01);
    bus.alu_result = 32'h0000_0099;
    expect_v("busy_held", S_BRS, 32'd1);
    expect_v("rd9_byp", S_RD1, 32'h0000_0099);
    commit();
    tick();

    idle();
    expect_v("busy_clr", S_BRS, 32'd0);
    expect_v("rd9", S_RD1, 32'h0000_0099);
    tick();

    ctl(3'b001, 2'b10);
    bus.rd = 5'd0;
    bus.rs = 5'd0;
    bus.rt = 5'd0;
    tick();

    idle();
    expect_v("busy_r0_rs", S_BRS, 32'd0);
    expect_v("busy_r0_rt", S_BRT, 32'd0);
    tick();

    ctl(3'b111, 2'b10);
    bus.rd         = 5'd4;
    bus.alu_result = 32'h0000_0044;
    bus.rs         = 5'd4;
    tick();

    idle();
    expect_v("bad_state", S_RD1, 32'h0);
    expect_v("bad_st_ack", S_ACK, 32'd0);
    tick();

    ctl(3'b011, 2'b10);
    bus.rd         = 5'd0;
    bus.alu_result = 32'hFFFF_FFFF;
    bus.rs         = 5'd0;
    expect_v("r0_byp", S_RD1, 32'h0);
    tick();

    idle();
    expect_v("r0_read", S_RD1, 32'h0);
    expect_v("r0_noack", S_ACK, 32'd0);
    expect_v("r0_cnt", S_CNT, {16'd0, exp_cnt});
    tick();

    ctl(3'b001, 2'b01);
    bus.rt = 5'd12;
    tick();

    RST = 1'b0;
    ctl(3'b011, 2'b10);
    bus.rd         = 5'd5;
    bus.alu_result = 32'h5555_5555;
    tick();

    RST = 1'b1;
    idle();
    bus.rs       = 5'd5;
    bus.rt       = 5'd12;
    bus.dbg_addr = 5'd3;
    exp_cnt      = 16'd0;
    expect_v("mrst_rd5", S_RD1, 32'h0);
    expect_v("mrst_busy", S_BRT, 32'd0);
    expect_v("mrst_dbg3", S_DBG, 32'h0);
    expect_v("mrst_cnt", S_CNT, 32'd0);
    expect_v("mrst_ack", S_ACK, 32'd0);
    tick();

    while (exp_cnt != 16'hFFFF) begin
      ctl(3'b011, 2'b10);
      bus.rd         = 5'd1;
      bus.alu_result = {16'd0, exp_cnt};
      commit();
      tick();
    end

    ctl(3'b011, 2'b10);
    bus.rd         = 5'd2;
    bus.alu_result = 32'h0000_2222;
    bus.rs         = 5'd2;
    commit();
    tick();

    idle();
    bus.dbg_addr = 5'd1;
    expect_v("wrap_cnt", S_CNT, 32'd0);
    expect_v("wrap_ack", S_ACK, 32'd1);
    expect_v("wrap_rd2", S_RD1, 32'h0000_2222);
    expect_v("wrap_dbg1", S_DBG, 32'h0000_FFFE);
    tick();
    tick();
    tick();

    n_chk++;
    if (ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_ack: got %0d pending expected 0",
               ack_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
